// File: rtl/bram_bridge.sv
// rtl/bram_bridge.sv - core memory bus to flushable BRAM port initiator with 2-entry in-order response FIFO
// Optional feature macro: BRAM_BRIDGE_RANGE_CHECK_EN (out-of-window requests answer with error, no BRAM access)
module bram_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
    parameter int unsigned SIZE      = 32768,
    localparam int AW                = $clog2(SIZE)
) (
    input  logic          g_clk,
    input  logic          g_resetn,
    input  logic          mem_req,
    output logic          mem_gnt,
    input  logic          mem_wen,
    input  logic [3:0]    mem_strb,
    input  logic [31:0]   mem_addr,
    input  logic [31:0]   mem_wdata,
    output logic          mem_recv,
    input  logic          mem_ack,
    output logic          mem_error,
    output logic [31:0]   mem_rdata,
    input  logic          flush_req,
    input  logic [31:0]   flush_rng,
    output logic          flush_busy,
    output logic          bram_ena,
    output logic [3:0]    bram_wea,
    output logic [AW-1:0] bram_addra,
    output logic [31:0]   bram_dina,
    input  logic [31:0]   bram_douta,
    output logic          bram_flush_rand,
    output logic [31:0]   bram_flush_data
);

    logic [1:0]  fifo_count;
    logic [31:0] e0_data, e1_data;
    logic        e0_err, e1_err;
    logic        inflight, inflight_wen, inflight_err;
    logic        flush_pending;
    logic [31:0] flush_last;
    logic [2:0]  occupancy;
    logic        issue, range_err, push, pop;
    logic [31:0] push_data;

`ifdef BRAM_BRIDGE_RANGE_CHECK_EN
    localparam logic [31:0] WIN_MASK = ~(SIZE - 32'd1);
    assign range_err = (mem_addr & WIN_MASK) != BASE_ADDR;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[31:AW];
    assign range_err      = 1'b0;
`endif

    // Slots are reserved at grant time, so the FIFO can never overflow.
    assign occupancy  = {1'b0, fifo_count} + {2'b00, inflight};
    assign mem_gnt    = mem_req && g_resetn && !flush_pending && (occupancy < 3'd2);
    assign issue      = mem_req && mem_gnt;

    assign bram_ena   = issue && !range_err;
    assign bram_wea   = (bram_ena && mem_wen) ? mem_strb : 4'b0000;
    assign bram_addra = mem_addr[AW-1:0];
    assign bram_dina  = mem_wdata;

    assign push       = inflight;
    assign push_data  = (inflight_wen || inflight_err) ? 32'd0 : bram_douta;
    assign mem_recv   = fifo_count != 2'd0;
    assign pop        = mem_recv && mem_ack;
    assign mem_rdata  = mem_recv ? e0_data : 32'd0;
    assign mem_error  = mem_recv && e0_err;

    // A flush cycle takes the slot a grant would have used; the pending read
    // capture of the previous cycle is already in flight and is unaffected.
    assign flush_busy      = flush_pending;
    assign bram_flush_rand = flush_pending;
    assign bram_flush_data = flush_pending ? flush_rng : flush_last;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            fifo_count    <= 2'd0;
            e0_data       <= 32'd0;
            e1_data       <= 32'd0;
            e0_err        <= 1'b0;
            e1_err        <= 1'b0;
            inflight      <= 1'b0;
            inflight_wen  <= 1'b0;
            inflight_err  <= 1'b0;
            flush_pending <= 1'b0;
            flush_last    <= 32'd0;
        end else begin
            inflight      <= issue;
            inflight_wen  <= mem_wen;
            inflight_err  <= range_err;
            flush_pending <= !flush_pending && flush_req;
            if (flush_pending) begin
                flush_last <= flush_rng;
            end
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        e0_data <= push_data;
                        e0_err  <= inflight_err;
                    end else begin
                        e1_data <= push_data;
                        e1_err  <= inflight_err;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    e0_data    <= e1_data;
                    e0_err     <= e1_err;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        e0_data <= push_data;
                        e0_err  <= inflight_err;
                    end else begin
                        e0_data <= e1_data;
                        e0_err  <= e1_err;
                        e1_data <= push_data;
                        e1_err  <= inflight_err;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_bridge.sv
// tb/tb_bram_bridge.sv - directed self-checking bench for bram_bridge with a transaction-level reference model
module tb_bram_bridge;

`ifdef BRAM_BRIDGE_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        mem_req, mem_gnt, mem_wen, mem_recv, mem_ack, mem_error;
    logic [3:0]  mem_strb;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        flush_req, flush_busy;
    logic [31:0] flush_rng;
    logic        bram_ena, bram_flush_rand;
    logic [3:0]  bram_wea;
    logic [14:0] bram_addra;
    logic [31:0] bram_dina, bram_douta, bram_flush_data;

    bram_bridge dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen), .mem_strb(mem_strb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_recv(mem_recv), .mem_ack(mem_ack),
        .mem_error(mem_error), .mem_rdata(mem_rdata),
        .flush_req(flush_req), .flush_rng(flush_rng), .flush_busy(flush_busy),
        .bram_ena(bram_ena), .bram_wea(bram_wea), .bram_addra(bram_addra), .bram_dina(bram_dina),
        .bram_douta(bram_douta), .bram_flush_rand(bram_flush_rand), .bram_flush_data(bram_flush_data)
    );

    always #5 g_clk = ~g_clk;

    // BRAM with one-cycle registered read, read-before-write
    logic [31:0] bram_mem [0:8191];
    always @(posedge g_clk) begin
        if (bram_ena) begin
            bram_douta <= bram_mem[bram_addra[14:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wea[b]) bram_mem[bram_addra[14:2]][8*b +: 8] <= bram_dina[8*b +: 8];
        end
    end

    typedef struct {
        int          ready;
        logic [31:0] data;
        logic        err;
    } resp_t;

    resp_t       q[$];
    logic [31:0] ref_mem [0:8191];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        fp = 1'b0;
    logic [31:0] last_flush = 32'd0;
    logic        m_acc;
    logic        s_gnt, s_recv, s_err, s_ena, s_frand;
    logic [31:0] s_rdata, s_fdata;
    logic [14:0] s_addra;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour: a request is granted when no flush is pending and fewer
    // than two responses are owed; each response becomes visible two samples after
    // its grant sample and leaves in order when acknowledged.
    task automatic model_step();
        logic        acc, err, recv_e;
        logic [31:0] rexp;
        resp_t       r;
        cyc++;
        s_gnt = mem_gnt; s_recv = mem_recv; s_err = mem_error; s_rdata = mem_rdata;
        s_ena = bram_ena; s_addra = bram_addra; s_frand = bram_flush_rand; s_fdata = bram_flush_data;
        m_acc = 1'b0;
        if (!g_resetn) begin
            chk("rst_gnt", {31'd0, mem_gnt}, 32'd0);
            chk("rst_recv", {31'd0, mem_recv}, 32'd0);
            chk("rst_error", {31'd0, mem_error}, 32'd0);
            chk("rst_rdata", mem_rdata, 32'd0);
            chk("rst_ena", {31'd0, bram_ena}, 32'd0);
            chk("rst_wea", {28'd0, bram_wea}, 32'd0);
            chk("rst_frand", {31'd0, bram_flush_rand}, 32'd0);
            chk("rst_busy", {31'd0, flush_busy}, 32'd0);
            chk("rst_fdata", bram_flush_data, 32'd0);
            q.delete();
            fp = 1'b0;
            last_flush = 32'd0;
            return;
        end
        acc = mem_req && !fp && (q.size() < 2);
        err = RANGE_EN && ((mem_addr & 32'hFFFF_8000) != 32'h0001_0000);
        chk("gnt", {31'd0, mem_gnt}, {31'd0, acc});
        chk("ena", {31'd0, bram_ena}, {31'd0, acc && !err});
        chk("wea", {28'd0, bram_wea}, {28'd0, (acc && !err && mem_wen) ? mem_strb : 4'h0});
        if (acc && !err) begin
            chk("addra", {17'd0, bram_addra}, {17'd0, mem_addr[14:0]});
            chk("dina", bram_dina, mem_wdata);
        end
        chk("flush_rand", {31'd0, bram_flush_rand}, {31'd0, fp});
        chk("flush_busy", {31'd0, flush_busy}, {31'd0, fp});
        chk("flush_data", bram_flush_data, fp ? flush_rng : last_flush);
        recv_e = (q.size() > 0) && (q[0].ready <= cyc);
        chk("recv", {31'd0, mem_recv}, {31'd0, recv_e});
        if (recv_e) begin
            chk("rdata", mem_rdata, q[0].data);
            chk("error", {31'd0, mem_error}, {31'd0, q[0].err});
        end
        if (recv_e && mem_ack) void'(q.pop_front());
        if (acc) begin
            m_acc = 1'b1;
            rexp = (mem_wen || err) ? 32'd0 : ref_mem[mem_addr[14:2]];
            r.ready = cyc + 2;
            r.data  = rexp;
            r.err   = err;
            q.push_back(r);
            if (mem_wen && !err)
                for (int b = 0; b < 4; b++)
                    if (mem_strb[b]) ref_mem[mem_addr[14:2]][8*b +: 8] = mem_wdata[8*b +: 8];
        end
        if (fp) last_flush = flush_rng;
        fp = !fp && flush_req;
    endtask

    task automatic tick();
        @(negedge g_clk);
        model_step();
        @(posedge g_clk);
        #1;
    endtask

    task automatic do_req(input logic wen, input logic [3:0] strb, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        mem_req = 1'b1; mem_wen = wen; mem_strb = strb; mem_addr = addr; mem_wdata = wdata;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_acc && n < 20);
        if (!m_acc) chk("req_timeout", 32'd0, 32'd1);
        mem_req = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    initial begin
        g_resetn = 1'b0; mem_req = 1'b0; mem_wen = 1'b0; mem_strb = 4'h0; mem_addr = 32'd0;
        mem_wdata = 32'd0; mem_ack = 1'b1; flush_req = 1'b0; flush_rng = 32'd0;
        repeat (3) tick();
        chk("reset_recv_pin", {31'd0, s_recv}, 32'd0);
        chk("reset_fdata_pin", s_fdata, 32'd0);
        g_resetn = 1'b1;
        tick();

        // 1: full write then read-back latency
        do_req(1'b1, 4'hF, 32'h0001_0004, 32'hDEAD_BEEF);
        drain();
        do_req(1'b0, 4'h0, 32'h0001_0004, 32'd0);
        tick();
        chk("t1_recv_early", {31'd0, s_recv}, 32'd0);
        tick();
        chk("t1_recv", {31'd0, s_recv}, 32'd1);
        chk("t1_rdata", s_rdata, 32'hDEAD_BEEF);
        drain();

        // 2: byte-lane write; write response carries zero data
        do_req(1'b1, 4'b0010, 32'h0001_0004, 32'h0000_AB00);
        tick();
        tick();
        chk("t2_wresp", s_rdata, 32'd0);
        drain();
        do_req(1'b0, 4'h0, 32'h0001_0004, 32'd0);
        tick();
        tick();
        chk("t2_rdata", s_rdata, 32'hDEAD_ABEF);
        drain();

        // preload for ordering, aliasing and zero-strobe write
        do_req(1'b1, 4'hF, 32'h0001_0000, 32'h1234_5678);
        do_req(1'b1, 4'hF, 32'h0001_0010, 32'h1111_1111);
        do_req(1'b1, 4'hF, 32'h0001_0014, 32'h2222_2222);
        do_req(1'b1, 4'hF, 32'h0001_0018, 32'h3333_3333);
        do_req(1'b1, 4'h0, 32'h0001_0010, 32'hFFFF_FFFF);
        drain();

        // 3: backpressure limits outstanding responses to two
        mem_ack = 1'b0; mem_req = 1'b1; mem_wen = 1'b0;
        mem_addr = 32'h0001_0010; tick(); chk("t3_gnt0", {31'd0, s_gnt}, 32'd1);
        mem_addr = 32'h0001_0014; tick(); chk("t3_gnt1", {31'd0, s_gnt}, 32'd1);
        mem_addr = 32'h0001_0018; tick(); chk("t3_gnt2", {31'd0, s_gnt}, 32'd0);
        tick(); chk("t3_gnt3", {31'd0, s_gnt}, 32'd0);
        mem_ack = 1'b1;
        tick(); chk("t3_gnt4", {31'd0, s_gnt}, 32'd0);
        chk("t3_first", s_rdata, 32'h1111_1111);
        tick(); chk("t3_gnt5", {31'd0, s_gnt}, 32'd1);
        chk("t3_second", s_rdata, 32'h2222_2222);
        mem_req = 1'b0;
        tick(); tick();
        chk("t3_third", s_rdata, 32'h3333_3333);
        drain();

        // 4: flush takes one slot while a request is held
        mem_req = 1'b1; mem_addr = 32'h0001_0014; flush_req = 1'b1; flush_rng = 32'h5A5A_5A5A;
        tick(); chk("t4_gnt_a", {31'd0, s_gnt}, 32'd1);
        flush_req = 1'b0;
        tick();
        chk("t4_gnt_flush", {31'd0, s_gnt}, 32'd0);
        chk("t4_ena", {31'd0, s_ena}, 32'd0);
        chk("t4_rand", {31'd0, s_frand}, 32'd1);
        chk("t4_fdata", s_fdata, 32'h5A5A_5A5A);
        flush_rng = 32'hA5A5_0000;
        tick();
        chk("t4_gnt_b", {31'd0, s_gnt}, 32'd1);
        chk("t4_rand_off", {31'd0, s_frand}, 32'd0);
        chk("t4_fhold", s_fdata, 32'h5A5A_5A5A);
        mem_req = 1'b0;
        drain();

        // 5: address outside the window
        do_req(1'b0, 4'h0, 32'h0002_0000, 32'd0);
        chk("t5_ena", {31'd0, s_ena}, RANGE_EN ? 32'd0 : 32'd1);
        chk("t5_addra", {17'd0, s_addra}, 32'd0);
        tick(); tick();
        chk("t5_err", {31'd0, s_err}, RANGE_EN ? 32'd1 : 32'd0);
        chk("t5_rdata", s_rdata, RANGE_EN ? 32'd0 : 32'h1234_5678);
        drain();

        // 6: reset with queued responses drops them
        mem_ack = 1'b0;
        do_req(1'b0, 4'h0, 32'h0001_0010, 32'd0);
        do_req(1'b0, 4'h0, 32'h0001_0014, 32'd0);
        tick(); tick();
        g_resetn = 1'b0; mem_req = 1'b1; mem_addr = 32'h0001_0010;
        #1;
        chk("t6_recv_now", {31'd0, mem_recv}, 32'd0);
        chk("t6_gnt_now", {31'd0, mem_gnt}, 32'd0);
        tick(); tick();
        g_resetn = 1'b1; mem_req = 1'b0; mem_ack = 1'b1;
        tick();
        chk("t6_no_stale", {31'd0, s_recv}, 32'd0);
        do_req(1'b0, 4'h0, 32'h0001_0018, 32'd0);
        tick(); tick();
        chk("t6_rdata", s_rdata, 32'h3333_3333);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
